subtractor_iterative_4b_slice: RTL

- Multi-cycle unsigned/two's-complement subtractor: computes in0 - in1 on NBITS-wide operands.
- Datapath is a single 4-bit ripple-carry adder slice, iterated once per nibble. Subtraction is done as in0 + ~in1 + 1, with a registered carry between nibbles.
- Sits beside the ALU as the reverse-direction arithmetic unit: the subtract path paired with the existing 4-bit adder slice.
- Uses a latency-insensitive val/rdy handshake on both input and output.

---
 rtl/subtractor_iterative_4b_slice_if.sv | 24 ++
 rtl/subtractor_iterative_4b_slice.sv | 89 ++++++++
 2 files changed

// File: rtl/subtractor_iterative_4b_slice_if.sv
// subtractor_iterative_4b_slice_if: val/rdy operand and result bundle for the iterative subtractor
interface subtractor_iterative_4b_slice_if #(
    parameter int NBITS = 32
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in0;
    logic [NBITS-1:0] in1;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_val, in0, in1, out_rdy,
        input  in_rdy, out_val, diff, bout, zero
    );

    modport slave (
        input  in_val, in0, in1, out_rdy,
        output in_rdy, out_val, diff, bout, zero
    );
endinterface

// File: rtl/subtractor_iterative_4b_slice.sv
// subtractor_iterative_4b_slice: in0 - in1 computed one nibble per cycle as in0 + ~in1 + 1
module subtractor_iterative_4b_slice #(
    parameter int NBITS = 32
) (
    input logic                          clk,
    input logic                          rst,
    subtractor_iterative_4b_slice_if.slave bus
);
    localparam int NSLICES = NBITS / 4;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_res;
    logic [NBITS-1:0] r_diff;
    logic [NBITS-1:0] w_res_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_bout;
    logic             r_zero;
    logic             w_c;
    logic [3:0]       w_s;
    logic             w_last;
    logic             w_accept;

    // 4-bit adder slice on the low nibbles; the sum enters the result from the top
    always_comb begin
        {w_c, w_s} = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
        w_res_next = (r_res >> 4) | (NBITS'(w_s) << (NBITS - 4));
    end

    assign w_last       = (r_state == CALC) && (r_cnt == CW'(NSLICES - 1));
    assign w_accept     = (r_state == IDLE) && bus.in_val;
    assign bus.in_rdy   = (r_state == IDLE) && !rst;
    assign bus.out_val  = (r_state == DONE);
    assign bus.diff     = r_diff;
    assign bus.bout     = r_bout;
    assign bus.zero     = r_zero;

    // state register; reset wins over any handshake in flight
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_next;
    end

    // next state: accept in IDLE, iterate NSLICES nibbles, hold result until consumed
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = bus.in_val  ? CALC : IDLE;
            CALC:    w_state_next = w_last      ? DONE : CALC;
            DONE:    w_state_next = bus.out_rdy ? IDLE : DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // operand shifting, carry chain between nibbles and result capture on the last nibble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.in0;
            r_b     <= ~bus.in1;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == CALC) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_res   <= w_res_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= ~w_c;
                r_zero <= (w_res_next == '0);
            end
        end
    end
endmodule
